// File: rtl/axi_burst_addr_gen_pkg.sv
// Local types for the burst address generator: FSM encoding and latched burst context.
package axi_burst_addr_gen_pkg;

    localparam int unsigned LEN_WIDTH  = 8;
    localparam int unsigned SIZE_WIDTH = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [LEN_WIDTH-1:0]  len;
        logic [SIZE_WIDTH-1:0] size;
        axi_common::burst_t    burst;
        logic                  err;
    } burst_ctx_t;

endpackage

// File: rtl/axi_common.sv
// Shared AXI definitions used by slave-side address and response logic.
package axi_common;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam int unsigned PAGE_4K_BITS = 12;

    // WRAP bursts only allow 2, 4, 8 or 16 beats; the reserved encoding is never legal.
    function automatic logic axi_burst_len_legal(input burst_t burst, input logic [7:0] len);
        logic legal;
        legal = 1'b1;
        case (burst)
            BURST_WRAP: legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
            BURST_RSVD: legal = 1'b0;
            default:    legal = 1'b1;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/axi_burst_next_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, including the wrap bound.
module axi_burst_next_addr
    import axi_common::*;
#(
    parameter int unsigned ADDR_WIDTH = 48
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  burst_t                burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wsize;
    logic [ADDR_WIDTH-1:0] wrap_lower;
    logic [ADDR_WIDTH-1:0] wrap_upper;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] step_addr;

    assign bytes      = ADDR_WIDTH'(1) << size;
    assign wsize      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    // The wrap window is fixed for the whole burst, so it can be derived from any beat address.
    assign wrap_lower = cur_addr & ~(wsize - ADDR_WIDTH'(1));
    assign wrap_upper = wrap_lower + wsize;
    assign incr_addr  = (cur_addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    assign step_addr  = cur_addr + bytes;

    always_comb begin
        next_addr = cur_addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (step_addr == wrap_upper) ? wrap_lower : step_addr;
            default:    next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AW/AR request into per-beat addresses with last and error flags.
module axi_burst_addr_gen
    import axi_common::*;
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_len,
    input  logic [2:0]            req_size,
    input  burst_t                req_burst,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [7:0]            beat_idx,
    output logic                  beat_last,
    output logic                  beat_err
);

    localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

    state_e                state_q;
    state_e                state_d;
    burst_ctx_t            ctx_q;
    logic                  hs_beat;
    logic                  hs_last;
    logic                  load;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] req_mask;
    logic [ADDR_WIDTH-1:0] incr_last;
    logic                  page_cross;
    logic                  req_err;

    assign hs_beat = beat_valid & beat_ready;
    assign hs_last = hs_beat & beat_last;

    // Request legality, evaluated on the accepting cycle only.
    assign req_mask   = (ADDR_WIDTH'(1) << req_size) - ADDR_WIDTH'(1);
    assign incr_last  = (req_addr & ~req_mask) + (ADDR_WIDTH'(req_len) << req_size);
    assign page_cross = incr_last[ADDR_WIDTH-1:PAGE_4K_BITS] != req_addr[ADDR_WIDTH-1:PAGE_4K_BITS];
    assign req_err    = (req_burst == BURST_RSVD)
                      | (req_size > SIZE_WIDTH'(MAX_SIZE))
                      | ~axi_burst_len_legal(req_burst, req_len)
                      | ((req_burst == BURST_WRAP) & (|(req_addr & req_mask)))
                      | ((req_burst == BURST_INCR) & page_cross);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_BUSY;
            ST_BUSY: if (hs_last && !req_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A last-beat handshake reopens the request port in the same cycle for bubble-free chaining.
    always_comb begin
        req_ready = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                load      = req_valid;
            end
            ST_BUSY: begin
                req_ready = hs_last;
                load      = hs_last & req_valid;
                advance   = hs_beat & ~beat_last;
            end
            default: ;
        endcase
    end

    axi_burst_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_addr (
        .cur_addr  (beat_addr),
        .size      (ctx_q.size),
        .len       (ctx_q.len),
        .burst     (ctx_q.burst),
        .next_addr (next_addr)
    );

    // Beat register; errored bursts keep the request address on every beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_valid <= 1'b0;
            beat_id    <= '0;
            beat_addr  <= '0;
            beat_idx   <= '0;
            beat_last  <= 1'b0;
            beat_err   <= 1'b0;
            ctx_q      <= '0;
        end else if (load) begin
            beat_valid <= 1'b1;
            beat_id    <= req_id;
            beat_addr  <= req_addr;
            beat_idx   <= '0;
            beat_last  <= (req_len == 8'd0);
            beat_err   <= req_err;
            ctx_q      <= '{len: req_len, size: req_size, burst: req_burst, err: req_err};
        end else if (advance) begin
            beat_addr  <= ctx_q.err ? beat_addr : next_addr;
            beat_idx   <= beat_idx + 8'd1;
            beat_last  <= (beat_idx + 8'd1) == ctx_q.len;
        end else if (hs_last) begin
            beat_valid <= 1'b0;
        end
    end

endmodule
